wb_port_arbiter: RTL and testbench



---
 rtl/wb_port_arbiter.sv | 113 +++++++++++
 tb/tb_wb_port_arbiter.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: primary writeback has priority, and secondary results
// wait in a small FIFO with an anti-starvation override. The write-port controls are registered.
module wb_port_arbiter #(
    parameter int SQ_DEPTH = 2,
    parameter int MAX_WAIT = 3
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        p_valid,
    output logic        p_ready,
    input  logic        p_DBDataSrc,
    input  logic [31:0] p_result,
    input  logic [31:0] p_DataOut,
    input  logic [4:0]  p_rd,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [4:0]  s_rd,
    input  logic [31:0] s_data,
    output logic        RegWre,
    output logic [4:0]  WriteReg,
    output logic [31:0] DB,
    output logic        wb_src,
    output logic [2:0]  sq_count
);

    typedef enum logic [1:0] {
        GNT_IDLE,
        GNT_PRI,
        GNT_SEC
    } grant_t;

    localparam logic [1:0] LAST_IDX = 2'(SQ_DEPTH - 1);

    logic [4:0]  rd_mem   [SQ_DEPTH];
    logic [31:0] data_mem [SQ_DEPTH];
    logic [1:0]  wr_ptr;
    logic [1:0]  rd_ptr;
    logic [3:0]  wait_cnt;
    grant_t      grant;
    logic        force_sec;
    logic        push;
    logic        pop;

    assign s_ready   = (sq_count < 3'(SQ_DEPTH));
    assign push      = s_valid && s_ready;
    assign force_sec = (sq_count != '0) && (wait_cnt >= 4'(MAX_WAIT));
    assign p_ready   = !force_sec;
    assign pop       = (grant == GNT_SEC);

    always_comb begin
        grant = GNT_IDLE;
        if (force_sec)
            grant = GNT_SEC;
        else if (p_valid)
            grant = GNT_PRI;
        else if (sq_count != '0)
            grant = GNT_SEC;
    end

    // Storage is not reset: pointers and count alone define which entries are live.
    always_ff @(posedge CLK) begin
        if (push) begin
            rd_mem[wr_ptr]   <= s_rd;
            data_mem[wr_ptr] <= s_data;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            sq_count <= '0;
            wait_cnt <= '0;
            RegWre   <= 1'b0;
            WriteReg <= '0;
            DB       <= '0;
            wb_src   <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= (wr_ptr == LAST_IDX) ? '0 : wr_ptr + 2'd1;
            if (pop)
                rd_ptr <= (rd_ptr == LAST_IDX) ? '0 : rd_ptr + 2'd1;

            case ({push, pop})
                2'b10:   sq_count <= sq_count + 3'd1;
                2'b01:   sq_count <= sq_count - 3'd1;
                default: sq_count <= sq_count;
            endcase

            if (pop || sq_count == '0)
                wait_cnt <= '0;
            else if (wait_cnt != '1)
                wait_cnt <= wait_cnt + 4'd1;

            case (grant)
                GNT_PRI: begin
                    RegWre   <= (p_rd != '0);
                    WriteReg <= p_rd;
                    DB       <= p_DBDataSrc ? p_DataOut : p_result;
                    wb_src   <= 1'b0;
                end
                GNT_SEC: begin
                    RegWre   <= (rd_mem[rd_ptr] != '0);
                    WriteReg <= rd_mem[rd_ptr];
                    DB       <= data_mem[rd_ptr];
                    wb_src   <= 1'b1;
                end
                default: RegWre <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Randomized bench for wb_port_arbiter against a queue-based reference model of the
// arbitration rules, run in phases that stress starvation, FIFO-full, rd=0 and reset.
module tb_wb_port_arbiter;

    localparam int SQ_DEPTH = 2;
    localparam int MAX_WAIT = 3;

    logic        CLK = 1'b0;
    logic        RST;
    logic        p_valid;
    logic        p_ready;
    logic        p_DBDataSrc;
    logic [31:0] p_result;
    logic [31:0] p_DataOut;
    logic [4:0]  p_rd;
    logic        s_valid;
    logic        s_ready;
    logic [4:0]  s_rd;
    logic [31:0] s_data;
    logic        RegWre;
    logic [4:0]  WriteReg;
    logic [31:0] DB;
    logic        wb_src;
    logic [2:0]  sq_count;

    wb_port_arbiter #(.SQ_DEPTH(SQ_DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
        .CLK(CLK), .RST(RST),
        .p_valid(p_valid), .p_ready(p_ready), .p_DBDataSrc(p_DBDataSrc),
        .p_result(p_result), .p_DataOut(p_DataOut), .p_rd(p_rd),
        .s_valid(s_valid), .s_ready(s_ready), .s_rd(s_rd), .s_data(s_data),
        .RegWre(RegWre), .WriteReg(WriteReg), .DB(DB), .wb_src(wb_src),
        .sq_count(sq_count)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } entry_t;

    entry_t      q[$];
    int          waited;
    logic        exp_regwre;
    logic [4:0]  exp_wreg;
    logic [31:0] exp_db;
    logic        exp_src;
    int          errors = 0;
    int          checks = 0;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        waited     = 0;
        exp_regwre = 1'b0;
        exp_wreg   = '0;
        exp_db     = '0;
        exp_src    = 1'b0;
    endtask

    // One clock of the reference model, using the inputs currently applied.
    task automatic model_step();
        int     occ;
        bit     forced;
        bit     sec_win;
        entry_t e;
        occ     = q.size();
        forced  = (occ > 0) && (waited >= MAX_WAIT);
        sec_win = forced || (!p_valid && occ > 0);
        if (sec_win) begin
            e          = q.pop_front();
            exp_regwre = (e.rd != 0);
            exp_wreg   = e.rd;
            exp_db     = e.data;
            exp_src    = 1'b1;
        end else if (p_valid) begin
            exp_regwre = (p_rd != 0);
            exp_wreg   = p_rd;
            exp_db     = p_DBDataSrc ? p_DataOut : p_result;
            exp_src    = 1'b0;
        end else begin
            exp_regwre = 1'b0;
        end
        if (sec_win || occ == 0)
            waited = 0;
        else if (waited < 15)
            waited = waited + 1;
        if (s_valid && occ < SQ_DEPTH) begin
            e.rd   = s_rd;
            e.data = s_data;
            q.push_back(e);
        end
    endtask

    task automatic check_outputs();
        check("RegWre", 32'(RegWre), 32'(exp_regwre));
        if (exp_regwre) begin
            check("WriteReg", 32'(WriteReg), 32'(exp_wreg));
            check("DB", DB, exp_db);
            check("wb_src", 32'(wb_src), 32'(exp_src));
        end
    endtask

    task automatic check_ready();
        bit exp_force;
        exp_force = (q.size() > 0) && (waited >= MAX_WAIT);
        check("p_ready", 32'(p_ready), 32'(!exp_force));
        check("s_ready", 32'(s_ready), 32'(q.size() < SQ_DEPTH));
        check("sq_count", 32'(sq_count), 32'(q.size()));
    endtask

    task automatic drive(input int p_pct, input int s_pct, input int rd0_pct, input int rst_pct);
        RST         = ($urandom_range(0, 99) < rst_pct);
        p_valid     = ($urandom_range(0, 99) < p_pct);
        p_DBDataSrc = $urandom_range(0, 1) == 1;
        p_result    = $urandom;
        p_DataOut   = $urandom;
        p_rd        = ($urandom_range(0, 99) < rd0_pct) ? 5'd0 : 5'($urandom_range(1, 31));
        s_valid     = ($urandom_range(0, 99) < s_pct);
        s_rd        = ($urandom_range(0, 99) < rd0_pct) ? 5'd0 : 5'($urandom_range(1, 31));
        s_data      = $urandom;
    endtask

    initial begin
        int p_tab[5]   = '{50, 95, 10, 40, 60};
        int s_tab[5]   = '{50, 30, 90, 60, 80};
        int rd0_tab[5] = '{5, 5, 5, 50, 10};
        int rst_tab[5] = '{0, 0, 0, 0, 4};

        drive(0, 0, 0, 100);
        @(negedge CLK);
        @(negedge CLK);
        model_reset();
        RST     = 1'b0;
        p_valid = 1'b0;
        s_valid = 1'b0;
        #1;
        check("reset_RegWre", 32'(RegWre), 32'd0);
        check("reset_WriteReg", 32'(WriteReg), 32'd0);
        check("reset_DB", DB, 32'd0);
        check("reset_wb_src", 32'(wb_src), 32'd0);
        check_ready();

        for (int ph = 0; ph < 5; ph++) begin
            for (int cyc = 0; cyc < 400; cyc++) begin
                drive(p_tab[ph], s_tab[ph], rd0_tab[ph], rst_tab[ph]);
                #1;
                check_ready();
                if (RST)
                    model_reset();
                else
                    model_step();
                @(negedge CLK);
                check_outputs();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
